// File: rtl/led_pkg.sv
// Shared types and constants for the LED display arbiter: FSM states, digit
// geometry and the hex-to-segment table ({dp,g,f,e,d,c,b,a}, active-low).
package led_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational nibble + decimal point + blank -> active-low segment byte.
module hex7seg_enc
    import led_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] hex_byte;

    assign hex_byte = HEX_SEG[nibble];

    // Bit 7 is the active-low decimal point.
    assign seg = blank ? SEG_BLANK : {hex_byte[7] & ~dp, hex_byte[6:0]};

endmodule

// File: rtl/led_disp_arb.sv
// Round-robin, burst-limited write arbiter that owns the 64-bit segment image.
// Define LED_DISP_ARB_RAW_SEG_EN to add verbatim segment-byte writes.
module led_disp_arb
    import led_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*3-1:0] req_digit,
    input  logic [NREQ*4-1:0] req_data,
    input  logic [NREQ-1:0]   req_dp,
    input  logic [NREQ-1:0]   req_blank,
`ifdef LED_DISP_ARB_RAW_SEG_EN
    input  logic [NREQ-1:0]   req_raw,
    input  logic [NREQ*8-1:0] req_seg,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              busy,
    output logic [63:0]       seg_buf
);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_SERVE  = SERVE;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [2:0] LAST_REQ  = 3'(NREQ - 1);

    logic [0:0]  state_q,     state_d;
    logic [2:0]  owner_q,     owner_d;
    logic [2:0]  rr_ptr_q,    rr_ptr_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [63:0] seg_buf_q,   seg_buf_d;

    logic       sel_req;
    logic [2:0] sel_digit;
    logic [3:0] sel_data;
    logic       sel_dp;
    logic       sel_blank;
    logic [7:0] enc_byte;
    logic [7:0] wr_byte;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic [2:0] next_ptr;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        sel_req   = 1'b0;
        sel_digit = '0;
        sel_data  = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == 3'(k)) begin
                sel_req   = req[k];
                sel_digit = req_digit[3*k +: 3];
                sel_data  = req_data[4*k +: 4];
                sel_dp    = req_dp[k];
                sel_blank = req_blank[k];
            end
        end
    end

    hex7seg_enc u_enc (
        .nibble (sel_data),
        .dp     (sel_dp),
        .blank  (sel_blank),
        .seg    (enc_byte)
    );

`ifdef LED_DISP_ARB_RAW_SEG_EN
    logic       sel_raw;
    logic [7:0] sel_seg;

    always_comb begin
        sel_raw = 1'b0;
        sel_seg = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == 3'(k)) begin
                sel_raw = req_raw[k];
                sel_seg = req_seg[8*k +: 8];
            end
        end
    end

    assign wr_byte = sel_raw ? sel_seg : enc_byte;
`else
    assign wr_byte = enc_byte;
`endif

    // First requester at or after rr_ptr, wrapping at NREQ-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pick_vld && req[k] && (((int'(rr_ptr_q) + i) % NREQ) == k)) begin
                    pick_vld = 1'b1;
                    pick_idx = 3'(k);
                end
            end
        end
    end

    assign next_ptr = (owner_q == LAST_REQ) ? 3'd0 : owner_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        seg_buf_d   = seg_buf_q;
        if (state_q == ST_IDLE) begin
            if (pick_vld) begin
                state_d     = ST_SERVE;
                owner_d     = pick_idx;
                burst_cnt_d = '0;
            end
        end else begin
            if (sel_req) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (sel_digit == 3'(d)) begin
                        seg_buf_d[8*(NUM_DIGITS-1-d) +: 8] = wr_byte;
                    end
                end
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
            if (!sel_req || (burst_cnt_q == LAST_BEAT)) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = (state_q == ST_SERVE) && (owner_q == 3'(k)) && req[k];
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            // NOTE: the segment image is reset rather than left unknown, since the scanner drives the LEDs from it directly.
            seg_buf_q   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            seg_buf_q   <= seg_buf_d;
        end
    end

    assign owner   = owner_q;
    assign busy    = (state_q == ST_SERVE);
    assign seg_buf = seg_buf_q;

endmodule

// File: tb/tb_led_disp_arb.sv
// Self-checking bench for led_disp_arb: behavioural model compared every cycle,
// directed scenarios with hand-computed images, then randomized requester traffic.
module tb_led_disp_arb;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*3-1:0] req_digit;
    logic [NREQ*4-1:0] req_data;
    logic [NREQ-1:0]   req_dp;
    logic [NREQ-1:0]   req_blank;
`ifdef LED_DISP_ARB_RAW_SEG_EN
    logic [NREQ-1:0]   req_raw;
    logic [NREQ*8-1:0] req_seg;
`endif
    logic [NREQ-1:0]   gnt;
    logic [2:0]        owner;
    logic              busy;
    logic [63:0]       seg_buf;

    led_disp_arb #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_digit (req_digit),
        .req_data  (req_data),
        .req_dp    (req_dp),
        .req_blank (req_blank),
`ifdef LED_DISP_ARB_RAW_SEG_EN
        .req_raw   (req_raw),
        .req_seg   (req_seg),
`endif
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .seg_buf   (seg_buf)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Segment patterns written out independently of the design package.
    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Behavioural model: who owns the bus, how many writes it has had, and the eight digit bytes.
    int         m_busy;
    int         m_owner;
    int         m_rr;
    int         m_cnt;
    logic [7:0] m_digits [8];

    typedef struct {
        logic [2:0] digit;
        logic [3:0] data;
        logic       dp;
        logic       blank;
        int         gap;
    } wr_t;

    wr_t             wq [NREQ][$];
    int              hold_c [NREQ];
    logic [NREQ-1:0] gnt_s;
    int              gnt_who [$];
    int              gnt_cyc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d, input logic dp, input logic bl);
        if (bl) return 8'hFF;
        return dp ? (hex_tab[d] & 8'h7F) : hex_tab[d];
    endfunction

    function automatic logic [63:0] model_image();
        logic [63:0] img;
        for (int d = 0; d < 8; d++) img[63-8*d -: 8] = m_digits[d];
        return img;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
        for (int d = 0; d < 8; d++) m_digits[d] = 8'hFF;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_busy != 0) begin
            if (req[m_owner]) begin
                m_digits[req_digit[3*m_owner +: 3]] =
                    enc(req_data[4*m_owner +: 4], req_dp[m_owner], req_blank[m_owner]);
                m_cnt++;
            end
            if (!req[m_owner] || m_cnt == MAX_BURST) begin
                m_busy = 0;
                m_rr   = (m_owner + 1) % NREQ;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_busy == 0 && req[(m_rr + i) % NREQ]) begin
                    m_owner = (m_rr + i) % NREQ;
                    m_busy  = 1;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_busy != 0 && req[m_owner]) eg[m_owner] = 1'b1;
        check("gnt", 64'(gnt), 64'(eg));
        check("busy", 64'(busy), 64'(m_busy != 0));
        if (m_busy != 0) check("owner", 64'(owner), 64'(m_owner));
        check("seg_buf", seg_buf, model_image());
        gnt_s = gnt;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_who.push_back(k);
                gnt_cyc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic drive();
        req       = '0;
        req_digit = '0;
        req_data  = '0;
        req_dp    = '0;
        req_blank = '0;
`ifdef LED_DISP_ARB_RAW_SEG_EN
        req_raw   = '0;
        req_seg   = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (wq[k].size() != 0 && hold_c[k] == 0) begin
                req[k]             = 1'b1;
                req_digit[3*k +: 3] = wq[k][0].digit;
                req_data[4*k +: 4]  = wq[k][0].data;
                req_dp[k]          = wq[k][0].dp;
                req_blank[k]       = wq[k][0].blank;
            end
        end
    endtask

    // Requesters react to the grant they saw: advance to the next write or hold off.
    task automatic requesters_update();
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_s[k] && wq[k].size() != 0) begin
                wq[k].delete(0);
                if (wq[k].size() != 0) hold_c[k] = wq[k][0].gap;
            end else if (hold_c[k] > 0) begin
                hold_c[k]--;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        requesters_update();
        drive();
    endtask

    task automatic push_wr(input int k, input int digit, input int data, input bit dp,
                           input bit blank, input int gap);
        wr_t w;
        w.digit = 3'(digit);
        w.data  = 4'(data);
        w.dp    = dp;
        w.blank = blank;
        w.gap   = gap;
        if (wq[k].size() == 0) hold_c[k] = gap;
        wq[k].push_back(w);
    endtask

    function automatic bit all_done();
        for (int k = 0; k < NREQ; k++) if (wq[k].size() != 0) return 1'b0;
        return m_busy == 0;
    endfunction

    task automatic run_until_idle(input int max_cycles);
        bit done;
        done = all_done();
        for (int i = 0; i < max_cycles && !done; i++) begin
            cycle();
            done = all_done();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: still busy after %0d cycles, expected idle", max_cycles);
        end
    endtask

    task automatic clear_log();
        gnt_who.delete();
        gnt_cyc.delete();
    endtask

    function automatic logic [31:0] packed_log();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < gnt_who.size() && i < 8; i++) p = (p << 4) | 32'(gnt_who[i]);
        return p;
    endfunction

    // Asserted between edges: outputs must clear without waiting for a clock.
    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_seg", seg_buf, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_async_gnt", 64'(gnt), 64'h0);
        check("rst_async_busy", 64'(busy), 64'h0);
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) hold_c[k] = 0;
        gnt_s = '0;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        reset_dut();

        // Single write: requester 2, digit 0, hex 5 with dp -> 8'h12 at the top byte.
        clear_log();
        c0 = cyc;
        push_wr(2, 0, 5, 1'b1, 1'b0, 0);
        drive();
        run_until_idle(20);
        check("single_img", seg_buf, 64'h12FF_FFFF_FFFF_FFFF);
        check("single_gnt_count", 64'(gnt_who.size()), 64'd1);
        check("single_gnt_who", 64'(gnt_who[0]), 64'd2);
        check("single_gnt_latency", 64'(gnt_cyc[0] - c0), 64'd1);

        // Round-robin: everyone requests, writes one digit, drops, then requests again.
        reset_dut();
        clear_log();
        for (int k = 0; k < NREQ; k++) begin
            push_wr(k, k, k, 1'b0, 1'b0, 0);
            push_wr(k, k + 4, k + 4, 1'b0, 1'b0, 1);
        end
        drive();
        run_until_idle(60);
        check("rr_order", 64'(packed_log()), 64'h0123_0123);
        check("rr_spacing", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd3);
        check("rr_img", seg_buf, 64'hC0F9_A4B0_9992_82F8);

        // Burst limit: requester 1 wants 6 writes while requester 3 waits.
        reset_dut();
        clear_log();
        for (int i = 0; i < 6; i++) push_wr(1, i, 6 + i, 1'b0, 1'b0, 0);
        push_wr(3, 7, 15, 1'b0, 1'b0, 0);
        drive();
        run_until_idle(60);
        check("burst_order", 64'(packed_log()), 64'h0111_1311);
        check("burst_back_to_back", 64'(gnt_cyc[3] - gnt_cyc[0]), 64'd3);
        check("burst_one_idle", 64'(gnt_cyc[4] - gnt_cyc[3]), 64'd2);
        check("burst_img", seg_buf, 64'h82F8_8090_8883_FF8E);

        // Blank/overwrite of digit 7 with digit 3 as a bystander.
        reset_dut();
        push_wr(0, 3, 0, 1'b0, 1'b0, 0);
        push_wr(0, 7, 10, 1'b0, 1'b0, 0);
        drive();
        run_until_idle(30);
        check("write_a_img", seg_buf, 64'hFFFF_FFC0_FFFF_FF88);
        push_wr(0, 7, 10, 1'b0, 1'b1, 0);
        drive();
        run_until_idle(30);
        check("blank_img", seg_buf, 64'hFFFF_FFC0_FFFF_FFFF);

        // Reset mid-burst: owner 0 has committed one write when rst hits.
        reset_dut();
        clear_log();
        for (int i = 1; i <= 4; i++) push_wr(0, i, i, 1'b0, 1'b0, 0);
        drive();
        cycle();
        cycle();
        check("midburst_busy_before", 64'(busy), 64'h1);
        reset_dut();
        clear_log();
        c0 = cyc;
        run_until_idle(30);
        check("midburst_regrant_who", 64'(gnt_who[0]), 64'd0);
        check("midburst_regrant_latency", 64'(gnt_cyc[0] - c0), 64'd1);
        check("midburst_img", seg_buf, 64'hFFFF_A4B0_99FF_FFFF);

        // Randomized traffic against the model.
        reset_dut();
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (wq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 6));
                    for (int j = 0; j < len; j++) begin
                        push_wr(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
                    end
                end
            end
            drive();
            cycle();
        end
        run_until_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_disp_arb.md
Name: led_disp_arb

Overview:
- Multi-requester write arbiter and display-buffer owner for the 8-digit seven-segment scanner.
- Up to NREQ client blocks (status, counters, debug) request single-digit hex writes.
- The block grants them round-robin with a bounded burst, encodes hex to segment patterns, and holds the 64-bit segment image.
- seg_buf drives the scanner's 64-bit input directly. Digit 0 is the leftmost digit, at bits [63:56]; digit 7 is at bits [7:0].

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive writes one owner may commit before forced rotation (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request; level, held until gnt.
- req_digit  in  NREQ*3  digit index per requester. Requester k uses [3k+2:3k].
- req_data  in  NREQ*4  hex nibble per requester. Requester k uses [4k+3:4k].
- req_dp  in  NREQ  decimal point on (1) per requester.
- req_blank  in  NREQ  blank the addressed digit instead of writing hex.
- gnt  out  NREQ  one-hot; high in the cycle a requester's write commits.
- owner  out  3  index of the current owner; valid while busy.
- busy  out  1  high in SERVE state.
- seg_buf  out  64  segment image to the scanner.

Behaviour:
- Segment byte format: {dp,g,f,e,d,c,b,a}, active-low.
  - Blank = 8'hFF.
  - hex 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - dp=1 clears bit 7.
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, burst_cnt=0, owner=0, busy=0, gnt=0.
  - seg_buf=64'hFFFF_FFFF_FFFF_FFFF (all digits blank).
  - Reset mid-burst aborts the burst; no gnt is issued in that cycle.
- FSM states: IDLE, SERVE.
- IDLE:
  - If any req is high, pick the first requester with req=1 searching from rr_ptr upward, wrapping at NREQ-1 to 0.
  - Latch it into owner, set burst_cnt=0, go to SERVE.
  - No write occurs in IDLE. busy=0, gnt=0.
- SERVE:
  - gnt[owner] = req[owner]. gnt is combinational from the registered state/owner and the live req.
  - If req[owner]=1, commit at this clock edge: seg_buf byte for req_digit[owner] is set to the encoded value (or FF if req_blank), then burst_cnt increments.
  - Leave SERVE for IDLE when req[owner]=0, or when a write commits with burst_cnt==MAX_BURST-1.
  - On leaving, rr_ptr = owner+1 mod NREQ.
- Latency and throughput:
  - Request in IDLE at cycle n -> gnt at cycle n+1.
  - One write per cycle within a burst.
  - Ownership change costs exactly one IDLE cycle.
- Requester rules:
  - Data/digit/dp/blank must be stable while req=1.
  - After seeing gnt, the requester may present new data the next cycle (continuing the burst) or drop req.
- Simultaneous requests: round-robin only; no fixed priority.
  - Requesters other than the owner see gnt=0 and wait.
- Owner drops req in SERVE: no write, no gnt, return to IDLE that edge.
- Untouched digits keep their previous bytes. Only the addressed byte changes per commit.
- Unused bits of owner (when NREQ<8) read 0.

Optional Feature:
- Macro: LED_DISP_ARB_RAW_SEG_EN.
- When defined:
  - Extra ports req_raw (in, NREQ) and req_seg (in, NREQ*8).
  - With req_raw[k]=1, requester k's commit writes req_seg[8k+7:8k] verbatim.
  - req_data, req_dp and req_blank are ignored for that commit.
- When undefined: ports are absent; hex encoding only.

Decomposition:
- Shared package led_pkg:
  - state enum (IDLE, SERVE).
  - SEG_BLANK=8'hFF.
  - The 16-entry hex-to-segment constant table.
  - NUM_DIGITS=8.
- Sub-module: hex7seg_enc, a combinational nibble+dp+blank -> byte encoder.
- Arbitration and the buffer stay in led_disp_arb.

Test Plan:
- Reset: assert rst mid-simulation -> seg_buf=64'hFFFF_FFFF_FFFF_FFFF, gnt=0, busy=0 immediately (async); hold rst 3 cycles, release, no spurious gnt.
- Single write: requester 2 sends digit 0, data 4'h5, dp=1 -> gnt[2] one cycle after req, seg_buf[63:56]=8'h12, other bytes FF.
- Round-robin: req=4'b1111 continuously, each writing 1 digit then dropping -> gnt order 0,1,2,3,0, with one IDLE cycle between owners.
- Burst limit: requester 1 holds req with 6 writes, requester 3 also requesting, MAX_BURST=4 -> requester 1 gets 4 consecutive gnt, then IDLE, then requester 3 granted; requester 1 regains later.
- Blank/overwrite: write digit 7 = 4'hA (seg_buf[7:0]=8'h88), then blank digit 7 -> seg_buf[7:0]=8'hFF, other bytes unchanged.
- Reset mid-burst: rst during SERVE with owner 0 -> no write for that cycle, rr_ptr=0, next request from requester 0 granted after one IDLE cycle.
